// File: rtl/bus_uart_tx_if.sv
// Bus-side signals of the memory-mapped UART transmitter.
interface bus_uart_tx_if;
    logic        busSel;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [31:0] busRData;

    modport master (
        output busSel,
        output busWe,
        output busAddr,
        output busWData,
        input  busRData
    );

    modport slave (
        input  busSel,
        input  busWe,
        input  busAddr,
        input  busWData,
        output busRData
    );
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register file, TX FIFO and serializer.
module bus_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_RESET  = 868
) (
    input  logic             clk,
    input  logic             reset,
    bus_uart_tx_if.slave     bus,
    output logic             tx,
    output logic             irq_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } state_e;

    // Register state
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_tx_en;
    logic          r_ovf;
    logic [15:0]   r_baud;

    state_e        r_state;
    logic [7:0]    r_shreg;
    logic [15:0]   r_div;
    logic [15:0]   r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic          r_tx;

    // Decode and handshake wires
    logic          w_sel_wr;
    logic          w_wr_ctrl;
    logic          w_wr_status;
    logic          w_wr_data;
    logic          w_wr_baud;
    logic          w_empty;
    logic          w_full;
    logic          w_busy;
    logic          w_bit_end;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_set;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;

    assign w_sel_wr    = bus.busSel & bus.busWe;
    assign w_wr_ctrl   = w_sel_wr & (bus.busAddr[3:2] == 2'd0);
    assign w_wr_status = w_sel_wr & (bus.busAddr[3:2] == 2'd1);
    assign w_wr_data   = w_sel_wr & (bus.busAddr[3:2] == 2'd2);
    assign w_wr_baud   = w_sel_wr & (bus.busAddr[3:2] == 2'd3);

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_busy    = (r_state != StIdle);
    assign w_bit_end = (r_baud_cnt == r_div);

    // Pop when idle, or at the end of a stop bit for back-to-back frames.
    assign w_pop = r_tx_en & ~w_empty &
                   ((r_state == StIdle) | ((r_state == StStop) & w_bit_end));

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_push    = w_wr_data & (~w_full | w_pop);
    assign w_ovf_set = w_wr_data & w_full & ~w_pop;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.busWData[7:0];
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Software-visible control registers; overflow set beats W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_en <= 1'b0;
            r_ovf   <= 1'b0;
            r_baud  <= 16'(DIV_RESET);
        end else begin
            if (w_wr_ctrl) begin
                r_tx_en <= bus.busWData[0];
            end
            if (w_wr_baud) begin
                r_baud <= bus.busWData[15:0];
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && bus.busWData[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serializer FSM with registered tx; the divisor is latched per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_shreg    <= '0;
            r_div      <= '0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shreg    <= r_mem[r_rptr];
                        r_div      <= r_baud;
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= StStart;
                    end
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shreg[0];
                        r_state    <= StData;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= StStop;
                        end else begin
                            r_shreg   <= r_shreg >> 1;
                            r_tx      <= r_shreg[1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shreg <= r_mem[r_rptr];
                            r_div   <= r_baud;
                            r_tx    <= 1'b0;
                            r_state <= StStart;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= StIdle;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // STATUS word assembly.
    always_comb begin
        w_status         = '0;
        w_status[0]      = w_full;
        w_status[1]      = w_empty;
        w_status[2]      = w_busy;
        w_status[3]      = r_ovf;
        w_status[8 +: CW] = r_count;
    end

    // Zero-wait read mux; returns 0 when the peripheral is not selected.
    always_comb begin
        w_rdata = '0;
        if (bus.busSel) begin
            unique case (bus.busAddr[3:2])
                2'd0: w_rdata = {31'd0, r_tx_en};
                2'd1: w_rdata = w_status;
                2'd2: w_rdata = '0;
                2'd3: w_rdata = {16'd0, r_baud};
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.busRData = w_rdata;
    assign tx           = r_tx;
    assign irq_empty    = w_empty & ~w_busy;

endmodule
